calc_ctrl: RTL

CALC_CTRL -- requirements
Module: calc_ctrl

---
 rtl/calc_pkg.sv | 71 +++++++
 rtl/calc_btn_edge.sv | 32 +++
 rtl/calc_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the calculator controller: operation encodings,
// controller state encoding, button bit positions and data widths, plus small
// decimal-digit helpers used by the digit counters.
// -----------------------------------------------------------------------------
package calc_pkg;

   localparam int RES_W  = 14;  // ALU magnitude width (99*99 = 9801 fits)
   localparam int BTN_W  = 9;   // number of button inputs
   localparam int OPND_W = 7;   // operand width (0..99)
   localparam int DIG_W  = 4;   // one decimal digit

   // Button bit positions within B
   localparam int B_MODE = 0;
   localparam int B_DIV  = 1;
   localparam int B_MUL  = 2;
   localparam int B_SUB  = 3;
   localparam int B_ADD  = 4;
   localparam int B_N1U  = 5;
   localparam int B_N1T  = 6;
   localparam int B_N2U  = 7;
   localparam int B_N2T  = 8;

   typedef enum logic [1:0] {
      OP_ADD = 2'd0,
      OP_SUB = 2'd1,
      OP_MUL = 2'd2,
      OP_DIV = 2'd3
   } op_e;

   typedef enum logic [1:0] {
      ST_INPUT = 2'd0,
      ST_READY = 2'd1,
      ST_BUSY  = 2'd2,
      ST_SHOW  = 2'd3
   } state_e;

   // Decimal digit increment, 9 wraps to 0 with no carry out.
   function automatic logic [DIG_W-1:0] dig_inc(input logic [DIG_W-1:0] d);
      logic [DIG_W-1:0] r;
      if (d >= 4'd9) begin
         r = 4'd0;
      end else begin
         r = d + 4'd1;
      end
      return r;
   endfunction

   // Two decimal digits to a binary operand value.
   function automatic logic [OPND_W-1:0] dig2bin(input logic [DIG_W-1:0] tens,
                                                 input logic [DIG_W-1:0] units);
      return ({3'd0, tens} * 7'd10) + {3'd0, units};
   endfunction

   // Resolve simultaneous operation presses: DIV > MUL > SUB > ADD.
   function automatic op_e pick_op(input logic [BTN_W-1:0] rise);
      op_e r;
      if (rise[B_DIV]) begin
         r = OP_DIV;
      end else if (rise[B_MUL]) begin
         r = OP_MUL;
      end else if (rise[B_SUB]) begin
         r = OP_SUB;
      end else begin
         r = OP_ADD;
      end
      return r;
   endfunction

endpackage

// File: rtl/calc_btn_edge.sv
// -----------------------------------------------------------------------------
// calc_btn_edge
// Registers the button levels once and flags the cycle in which each button
// goes from released to pressed, so a held button acts exactly once.
//   clk   in   system clock
//   rst   in   asynchronous active-high reset (clears the history)
//   b     in   [BTN_W] button levels, synchronous to clk
//   rise  out  [BTN_W] one-cycle rising-edge flags (b & ~previous b)
// -----------------------------------------------------------------------------
module calc_btn_edge
   import calc_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [BTN_W-1:0] b,
   output logic [BTN_W-1:0] rise
);

   logic [BTN_W-1:0] b_q_r;

   // Button history register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         b_q_r <= 9'd0;
      end else begin
         b_q_r <= b;
      end
   end

   assign rise = b & ~b_q_r;

endmodule

// File: rtl/calc_ctrl.sv
// -----------------------------------------------------------------------------
// calc_ctrl
// Button-driven controller for a two-operand decimal calculator. Collects two
// two-digit operands, issues one ALU operation at a time, waits (bounded) for
// the ALU answer and holds the result, sign and error flag for display.
//   clk         in   system clock, rising edge
//   rst         in   asynchronous active-high reset
//   B           in   [9] button levels: 0 mode, 1 div, 2 mul, 3 sub, 4 add,
//                    5 n1 units, 6 n1 tens, 7 n2 units, 8 n2 tens
//   alu_done    in   one-cycle ALU completion pulse
//   alu_result  in   [14] ALU magnitude, valid with alu_done
//   alu_neg     in   ALU sign, valid with alu_done
//   n1, n2      out  [7] operands 0..99
//   op_sel      out  [2] ADD=0 SUB=1 MUL=2 DIV=3
//   alu_start   out  one-cycle operation request
//   mode        out  0 = entering operands, 1 = operation/result phase
//   result      out  [14] latched result magnitude
//   neg         out  latched result sign
//   err         out  divide-by-zero or ALU timeout flag
// -----------------------------------------------------------------------------
module calc_ctrl
   import calc_pkg::*;
#(
   parameter int ALU_TIMEOUT = 64
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic [BTN_W-1:0]  B,
   input  logic              alu_done,
   input  logic [RES_W-1:0]  alu_result,
   input  logic              alu_neg,
   output logic [OPND_W-1:0] n1,
   output logic [OPND_W-1:0] n2,
   output logic [1:0]        op_sel,
   output logic              alu_start,
   output logic              mode,
   output logic [RES_W-1:0]  result,
   output logic              neg,
   output logic              err
);

   // Counter runs 0..ALU_TIMEOUT-1 while busy; the last value marks the final
   // cycle the ALU is allowed (an alu_done in that cycle is still accepted).
   localparam int CNT_W = (ALU_TIMEOUT > 1) ? $clog2(ALU_TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALU_TIMEOUT - 1);

   logic [BTN_W-1:0]  rise_s;
   logic              op_req_s;
   op_e               op_pick_s;

   state_e            state_r,  state_nx;
   logic [DIG_W-1:0]  u1_r, t1_r, u2_r, t2_r;
   logic [DIG_W-1:0]  u1_nx, t1_nx, u2_nx, t2_nx;
   logic [OPND_W-1:0] n1_r, n2_r, n1_nx, n2_nx;
   op_e               op_r, op_nx;
   logic              start_r, start_nx;
   logic              mode_r, mode_nx;
   logic [RES_W-1:0]  res_r, res_nx;
   logic              neg_r, neg_nx;
   logic              err_r, err_nx;
   logic [CNT_W-1:0]  cnt_r, cnt_nx;

   calc_btn_edge u_btn_edge (
      .clk  (clk),
      .rst  (rst),
      .b    (B),
      .rise (rise_s)
   );

   assign op_req_s  = |rise_s[B_ADD:B_DIV];
   assign op_pick_s = pick_op(rise_s);

   // Next-state and next-output logic
   always_comb begin
      state_nx = state_r;
      u1_nx    = u1_r;
      t1_nx    = t1_r;
      u2_nx    = u2_r;
      t2_nx    = t2_r;
      op_nx    = op_r;
      start_nx = 1'b0;
      res_nx   = res_r;
      neg_nx   = neg_r;
      err_nx   = err_r;
      cnt_nx   = cnt_r;

      case (state_r)
         ST_INPUT: begin
            // Several digit buttons may hit the same edge; each applies.
            if (rise_s[B_N1U]) begin
               u1_nx = dig_inc(u1_r);
            end else begin
               u1_nx = u1_r;
            end
            if (rise_s[B_N1T]) begin
               t1_nx = dig_inc(t1_r);
            end else begin
               t1_nx = t1_r;
            end
            if (rise_s[B_N2U]) begin
               u2_nx = dig_inc(u2_r);
            end else begin
               u2_nx = u2_r;
            end
            if (rise_s[B_N2T]) begin
               t2_nx = dig_inc(t2_r);
            end else begin
               t2_nx = t2_r;
            end
            if (rise_s[B_MODE]) begin
               state_nx = ST_READY;
            end else begin
               state_nx = ST_INPUT;
            end
         end

         ST_READY, ST_SHOW: begin
            // Mode toggle outranks any op pressed on the same edge.
            if (rise_s[B_MODE]) begin
               state_nx = ST_INPUT;
               err_nx   = 1'b0;
            end else if (op_req_s) begin
               op_nx = op_pick_s;
               if ((op_pick_s == OP_DIV) && (n2_r == 7'd0)) begin
                  // Divide by zero is answered locally, the ALU is not used.
                  res_nx   = '0;
                  neg_nx   = 1'b0;
                  err_nx   = 1'b1;
                  state_nx = ST_SHOW;
               end else begin
                  start_nx = 1'b1;
                  err_nx   = 1'b0;
                  cnt_nx   = '0;
                  state_nx = ST_BUSY;
               end
            end else begin
               state_nx = state_r;
            end
         end

         ST_BUSY: begin
            if (alu_done) begin
               res_nx   = alu_result;
               neg_nx   = alu_neg;
               state_nx = ST_SHOW;
            end else if (cnt_r == CNT_LAST) begin
               err_nx   = 1'b1;
               state_nx = ST_SHOW;
            end else begin
               cnt_nx   = cnt_r + 1'b1;
               state_nx = ST_BUSY;
            end
         end

         default: begin
            state_nx = ST_INPUT;
         end
      endcase

      n1_nx   = dig2bin(t1_nx, u1_nx);
      n2_nx   = dig2bin(t2_nx, u2_nx);
      mode_nx = (state_nx != ST_INPUT);
   end

   // State, digit and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_INPUT;
         u1_r    <= 4'd0;
         t1_r    <= 4'd0;
         u2_r    <= 4'd0;
         t2_r    <= 4'd0;
         n1_r    <= 7'd0;
         n2_r    <= 7'd0;
         op_r    <= OP_ADD;
         start_r <= 1'b0;
         mode_r  <= 1'b0;
         res_r   <= 14'd0;
         neg_r   <= 1'b0;
         err_r   <= 1'b0;
         cnt_r   <= '0;
      end else begin
         state_r <= state_nx;
         u1_r    <= u1_nx;
         t1_r    <= t1_nx;
         u2_r    <= u2_nx;
         t2_r    <= t2_nx;
         n1_r    <= n1_nx;
         n2_r    <= n2_nx;
         op_r    <= op_nx;
         start_r <= start_nx;
         mode_r  <= mode_nx;
         res_r   <= res_nx;
         neg_r   <= neg_nx;
         err_r   <= err_nx;
         cnt_r   <= cnt_nx;
      end
   end

   assign n1        = n1_r;
   assign n2        = n2_r;
   assign op_sel    = op_r;
   assign alu_start = start_r;
   assign mode      = mode_r;
   assign result    = res_r;
   assign neg       = neg_r;
   assign err       = err_r;

endmodule
